// File: rtl/i2c_pkg.sv
// Shared constants for the WM8731-style I2C codec responder.
// State encoding, codec register addresses and frame field widths.
package i2c_pkg;

  localparam int REG_W  = 7;
  localparam int D8_W   = 1;
  localparam int DATA_W = 9;

  localparam logic [REG_W-1:0] WM_RESET_REG  = 7'h0F;
  localparam logic [REG_W-1:0] WM_ACTIVE_REG = 7'h09;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ADDR      = 3'd1;
  localparam state_t S_ADDR_ACK  = 3'd2;
  localparam state_t S_BYTE1     = 3'd3;
  localparam state_t S_BYTE1_ACK = 3'd4;
  localparam state_t S_BYTE2     = 3'd5;
  localparam state_t S_BYTE2_ACK = 3'd6;
  localparam state_t S_WAIT_STOP = 3'd7;

endpackage

// File: rtl/i2c_line_cond.sv
// Per-line conditioning: 2-FF synchronizer, optional stability filter
// (I2C_GLITCH_FILTER_EN), previous-value register and edge flags.
module i2c_line_cond #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic line,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  if (FILTER_LEN < 1) begin : g_len_chk
    $error("FILTER_LEN must be at least 1");
  end

  // Reset to the idle bus level so release does not fake an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= line_in;
      s2 <= s1;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] cnt;
  logic          filt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b1;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign line = filt;
`else
  assign line = s2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= line;
  end

  assign rise = line & ~prev;
  assign fall = ~line & prev;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target decoding 3-byte WM8731 control frames into a 9-bit regfile.
// Optional input glitch filter via I2C_GLITCH_FILTER_EN.
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [REG_W-1:0] DEVICE_ADDR = 7'h1A,
  parameter int               NUM_REGS    = 16,
  parameter logic [REG_W-1:0] RESET_REG   = WM_RESET_REG,
  parameter logic [REG_W-1:0] ACTIVE_REG  = WM_ACTIVE_REG,
  parameter int               FILTER_LEN  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [REG_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              codec_active,
  output logic              frame_err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clock   (clock),
    .reset   (reset),
    .line_in (scl_in),
    .line    (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clock   (clock),
    .reset   (reset),
    .line_in (sda_in),
    .line    (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_t            state;
  state_t            nxt;
  logic [2:0]        cnt;
  logic              full;
  logic [7:0]        sh;
  logic [REG_W-1:0]  reg_q;
  logic [D8_W-1:0]   d8_q;
  logic              extra;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic start, stop, bus_ev, byte_done;
  logic shifting, ack_st, addr_match, in_range;
  logic oe_d, commit, ferr_d, clr_all;
  logic [DATA_W-1:0] wdata;

  assign start      = sda_fall & scl;
  assign stop       = sda_rise & scl;
  assign bus_ev     = start | stop;
  assign byte_done  = scl_fall & full;
  assign addr_match = (sh[7:1] == DEVICE_ADDR) & ~sh[0];
  assign in_range   = int'(reg_q) < NUM_REGS;
  assign wdata      = {d8_q, sh};

  assign shifting = (state == S_ADDR) | (state == S_BYTE1) |
                    (state == S_BYTE2) | (state == S_WAIT_STOP);
  assign ack_st   = (state == S_ADDR_ACK) | (state == S_BYTE1_ACK) |
                    (state == S_BYTE2_ACK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = S_ADDR;
    end else if (stop) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_ADDR:
          if (byte_done) nxt = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (scl_fall)  nxt = S_BYTE1;
        S_BYTE1:     if (byte_done) nxt = S_BYTE1_ACK;
        S_BYTE1_ACK: if (scl_fall)  nxt = S_BYTE2;
        S_BYTE2:     if (byte_done) nxt = S_BYTE2_ACK;
        S_BYTE2_ACK: if (scl_fall)  nxt = S_WAIT_STOP;
        default:     nxt = state;
      endcase
    end
  end

  always_comb begin
    oe_d    = (nxt == S_ADDR_ACK) | (nxt == S_BYTE1_ACK) |
              (nxt == S_BYTE2_ACK);
    commit  = 1'b0;
    ferr_d  = 1'b0;
    if (bus_ev) begin
      // Frame cut short after the address was accepted.
      ferr_d = (state == S_BYTE1) | (state == S_BYTE1_ACK) |
               (state == S_BYTE2);
    end else if (byte_done) begin
      commit = (state == S_BYTE2) & in_range;
      ferr_d = ((state == S_BYTE2) & ~in_range) |
               ((state == S_WAIT_STOP) & extra);
    end
    clr_all = commit & (reg_q == RESET_REG);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= 3'd7;
      full  <= 1'b0;
      sh    <= '0;
      reg_q <= '0;
      d8_q  <= '0;
      extra <= 1'b0;
    end else begin
      if (bus_ev | (scl_fall & (full | ack_st))) begin
        cnt  <= 3'd7;
        full <= 1'b0;
      end else if (scl_rise & shifting) begin
        sh <= {sh[6:0], sda};
        if (cnt == 3'd0) full <= 1'b1;
        else             cnt  <= cnt - 1'b1;
      end
      if ((state == S_BYTE1) & byte_done) begin
        reg_q <= sh[7:1];
        d8_q  <= sh[0];
      end
      if (bus_ev)
        extra <= 1'b0;
      else if ((state == S_BYTE2_ACK) & scl_fall)
        extra <= 1'b1;
      else if ((state == S_WAIT_STOP) & byte_done)
        extra <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      sda_oe    <= oe_d;
      wr_valid  <= commit;
      frame_err <= ferr_d;
      if (commit) begin
        wr_addr <= reg_q;
        wr_data <= wdata;
      end
    end
  end

  // Registered read returns the pre-write value on a same-cycle hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data      <= '0;
      codec_active <= 1'b0;
    end else begin
      rd_data <= regs[AW'(rd_addr)];
      if (clr_all) begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        codec_active <= 1'b0;
      end else begin
        codec_active <= regs[ACTIVE_REG[AW-1:0]][0];
        if (commit) regs[reg_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- Synthesizable I2C target (responder) that receives the 3-byte WM8731-style control frames our codec configuration master issues.
- Frame layout: device address, then {reg[6:0], data[8]}, then data[7:0].
- Each decoded frame is committed into an on-chip 9-bit register file and reported as a write strobe.
- Uses: loop-back verification of the config master on the board, and standing in for the codec on builds without one.

Parameters:
- DEVICE_ADDR, 7'h1A, 7-bit target address the block responds to.
- NUM_REGS, 16, register-file depth; valid register addresses are 0 to NUM_REGS-1.
- RESET_REG, 7'h0F, register address whose write clears the whole file.
- ACTIVE_REG, 7'h09, register address whose bit 0 drives codec_active.
- FILTER_LEN, 4, stability count used only when I2C_GLITCH_FILTER_EN is defined.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- scl_in  in  1  I2C clock pin sample (asynchronous).
- sda_in  in  1  I2C data pin sample (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); the top level builds the tristate.
- wr_valid  out  1  one-cycle strobe when a register is committed.
- wr_addr  out  7  register address of the committed write.
- wr_data  out  9  data of the committed write.
- rd_addr  in  4  register-file read address.
- rd_data  out  9  registered read data, 1-cycle latency.
- codec_active  out  1  register ACTIVE_REG, bit 0.
- frame_err  out  1  one-cycle strobe on a malformed frame.

Behaviour:
- Reset:
  - All outputs 0; register file all 0; state IDLE.
  - sda_oe is released asynchronously, including mid-ACK.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus a previous-value register.
  - Edge flags scl_rise, scl_fall, start and stop are valid 3 clocks after the pin change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START or STOP takes priority over any state. START, including a repeated START, goes to ADDR with the bit count cleared. STOP goes to IDLE and releases sda_oe.
- Data sampling:
  - Data is sampled MSB first on scl_rise.
  - The bit counter runs 7 down to 0.
- States: IDLE, ADDR, ADDR_ACK, BYTE1, BYTE1_ACK, BYTE2, BYTE2_ACK, WAIT_STOP.
- ADDR:
  - After 8 bits, on scl_fall: if addr == DEVICE_ADDR and R/W == 0, assert sda_oe and go to ADDR_ACK.
  - Otherwise leave SDA released (NACK) and go to WAIT_STOP. No frame_err.
  - R/W = 1 (read) is always NACKed.
- ADDR_ACK / BYTE1_ACK:
  - sda_oe is held until the next scl_fall, then released; advance to the next byte state.
- BYTE1: 8 bits latched as {reg[6:0], d8}; ACK the same way as ADDR.
- BYTE2 commit, after 8 bits, on scl_fall:
  - If reg < NUM_REGS: write regfile[reg] = {d8, byte}, pulse wr_valid for one cycle with wr_addr/wr_data, assert sda_oe, go to BYTE2_ACK.
  - If reg >= NUM_REGS: still ACK, but no write, no wr_valid, and pulse frame_err.
- RESET_REG: a write to RESET_REG clears every register and codec_active on the same cycle and is not stored itself. wr_valid still pulses.
- BYTE2_ACK: release sda_oe on scl_fall, then go to WAIT_STOP.
- Extra bytes: a further byte before STOP is NACKed and pulses frame_err once, when its 8th bit completes.
- Short frames: a STOP or repeated START while in BYTE1, BYTE1_ACK or BYTE2 drops the frame and pulses frame_err. No write occurs.
- WAIT_STOP: ignores data and waits for STOP or START.
- codec_active: equals regfile[ACTIVE_REG][0], registered. It updates the cycle after the commit.
- Read port:
  - rd_data is registered, 1-cycle latency from rd_addr.
  - A read and a write to the same address in the same cycle returns the old value.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after synchronization, each line passes through a filter. The filtered value changes only after the raw value has been stable for FILTER_LEN consecutive clocks. Edge latency becomes 3 + FILTER_LEN clocks. Pulses shorter than FILTER_LEN clocks are ignored.
- Undefined: synchronizer only, 3-clock latency; every sampled transition counts.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding localparams;
  - the WM8731 register address constants (RESET_REG 0x0F, ACTIVE_REG 0x09);
  - the frame field widths (7/1/9).
- One sub-module: i2c_line_cond.
  - Instantiated once per line.
  - Contains the synchronizer, the optional filter under the macro, and previous-value/edge outputs.

Test Plan:
- Write 0x34,0x0E,0x02 with ACKs checked → three ACK low pulses; wr_valid once with wr_addr=7, wr_data=0x002; rd_addr=7 gives rd_data=0x002 one cycle later.
- Write 0x34,0x12,0x01 → codec_active rises 1 cycle after wr_valid. Then write 0x34,0x1E,0x00 → all registers 0, codec_active=0, wr_addr=0x0F.
- Address 0x36 (0x1B), and separately address 0x35 (read) → SDA never pulled low; no wr_valid; no frame_err.
- 0x34,0x0C then STOP → no write, frame_err one pulse; the next full frame 0x34,0x0C,0x00 commits reg 6 normally.
- 0x34,0x0E,0x02,0x55 → write commits; 4th byte NACKed; frame_err one pulse. Assert reset during the BYTE1 ACK → sda_oe drops to 0 immediately and the register file clears.
- With I2C_GLITCH_FILTER_EN and FILTER_LEN=4: 2-clock SCL glitches mid-byte → still exactly one commit with the correct data. Without the macro, the same stimulus → frame corrupted: frame_err or a wrong wr_data value.
